branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 16, meaning the BTB/counter table depth (power of two, 2..1024).
REQ-002 The block SHALL have parameter CTR_BITS, default 2, meaning the saturating-counter width (1..4).
REQ-003 The block SHALL have parameter GHR_BITS, default 0, meaning the global-history length: 0 selects bimodal mode, and 1..log2(NUM_ENTRIES) selects gshare mode.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: the synchronous, active-high reset.
REQ-007 The block SHALL have port pred_pc, input, 32 bits: the fetch PC looked up this cycle.
REQ-008 The block SHALL have port pred_hit, output, 1 bit: the lookup matched a valid entry.
REQ-009 The block SHALL have port pred_taken, output, 1 bit: the predicted direction.
REQ-010 The block SHALL have port pred_target, output, 32 bits: the predicted next PC.
REQ-011 The block SHALL have port update_valid, input, 1 bit: a resolved control-flow instruction this cycle.
REQ-012 The block SHALL have port update_pc, input, 32 bits: the PC of the resolved instruction.
REQ-013 The block SHALL have port update_taken, input, 1 bit: the resolved direction (jal/jalr are always 1).
REQ-014 The block SHALL have port update_target, input, 32 bits: the resolved taken target.

Function
REQ-015 The index SHALL be pc[IDX+1:2] XOR the zero-extended GHR, where IDX = log2(NUM_ENTRIES); the XOR term SHALL be 0 when GHR_BITS=0.
REQ-016 The tag SHALL be pc[31:IDX+2]; pc[1:0] SHALL be ignored.
REQ-017 Each entry SHALL hold valid, tag, a 32-bit target, and a CTR_BITS counter.
REQ-018 Lookup SHALL be combinational with zero latency: pred_hit = valid AND tag match; pred_taken = pred_hit AND counter MSB.
REQ-019 pred_target SHALL equal the stored target when pred_taken=1, else pred_pc+4, with modulo 2^32 wrap (0xFFFFFFFC -> 0x00000000).
REQ-020 An update that hits SHALL take effect at the next rising edge: the counter saturates up if taken and down if not taken, with no wrap at 0 or 2^CTR_BITS-1; the target is overwritten only if taken.
REQ-021 An update that misses and is taken SHALL allocate the entry, overwriting any valid entry: valid=1, new tag, target, counter = 2^(CTR_BITS-1) (weakly taken).
REQ-022 An update that misses and is not taken SHALL leave the table unchanged.
REQ-023 In gshare mode, GHR SHALL shift left inserting update_taken on every update_valid; the update index SHALL use the pre-shift GHR.
REQ-024 GHR SHALL be updated only on resolution (non-speculative); prediction SHALL use the current GHR.
REQ-025 When lookup and update address the same entry in the same cycle, lookup SHALL return the pre-update contents.
REQ-026 Only one update per cycle SHALL be supported; the block SHALL have no back-pressure and no handshake beyond update_valid.

Reset
REQ-027 While reset=1 at a rising edge, all valid bits SHALL clear, all counters SHALL become 2^(CTR_BITS-1)-1 (weakly not taken), and GHR SHALL become 0.
REQ-028 After reset, for any pred_pc, pred_hit=0, pred_taken=0, and pred_target=pred_pc+4.
REQ-029 reset SHALL take priority over a simultaneous update_valid; that update is dropped.

Structure
REQ-030 Counter-width limits, the weakly-taken/weakly-not-taken constants, and the entry record type SHALL live in the shared CPU package.
REQ-031 One sub-module, sat_counter (parametrised width, inc/dec/hold), is natural; table storage SHALL be flops, not memory macros.

Verification
REQ-032 The bench SHALL cover: after reset, pred_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-033 The bench SHALL cover: update pc=0x100, taken, target 0x40 -> next cycle pred_pc=0x100 gives pred_hit=1, pred_taken=1, pred_target=0x40.
REQ-034 The bench SHALL cover: after REQ-033, two not-taken updates of 0x100 -> pred_taken=0 (counter 0); a third not-taken update -> counter stays 0.
REQ-035 The bench SHALL cover: with NUM_ENTRIES=16, allocate 0x100 and then 0x140 (same index, different tag) -> lookup of 0x100 gives pred_hit=0.
REQ-036 The bench SHALL cover: pred_pc=0xFFFFFFFC with no entry -> pred_target=0x00000000.
REQ-037 The bench SHALL cover: with GHR_BITS=2, updates T,T at 0x200 -> the third lookup of 0x200 indexes entry 0 XOR 3 = 3; asserting reset during an update -> the table is empty the next cycle.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared predictor types: counter-width limits, counter reset/allocate
// constants and the table entry record.
package branch_predictor_pkg;

   localparam int CTR_BITS_MIN = 1;
   localparam int CTR_BITS_MAX = 4;
   // Widest tag occurs with a 2-entry table: pc[31:3].
   localparam int TAG_BITS_MAX = 29;

   // Fields are sized for the widest legal configuration; narrower
   // configurations store zero-extended tags and counters.
   typedef struct packed {
      logic                    valid;
      logic [TAG_BITS_MAX-1:0] tag;
      logic [31:0]             target;
      logic [CTR_BITS_MAX-1:0] ctr;
   } bp_entry_t;

   // Value given to a freshly allocated entry.
   function automatic logic [CTR_BITS_MAX-1:0] ctr_weak_taken(input int bits);
      return CTR_BITS_MAX'(1 << (bits - 1));
   endfunction

   // Value every counter takes at reset.
   function automatic logic [CTR_BITS_MAX-1:0] ctr_weak_not_taken(input int bits);
      return CTR_BITS_MAX'((1 << (bits - 1)) - 1);
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-state logic; holds when neither
// inc nor dec is set and never wraps at either end.
module sat_counter
   import branch_predictor_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [W-1:0] cnt,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] nxt
);

   // Step toward the requested direction unless already at the rail.
   always_comb begin
      nxt = cnt;
      if (inc && (cnt != '1))
         nxt = cnt + 1'b1;
      else if (dec && (cnt != '0))
         nxt = cnt - 1'b1;
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Bimodal when GHR_BITS=0, gshare (pc index XOR global history) otherwise.
// Lookup is combinational; updates land on the next rising edge.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int NUM_ENTRIES = 16,
   parameter int CTR_BITS    = 2,
   parameter int GHR_BITS    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pred_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target
);

   localparam int IDX = $clog2(NUM_ENTRIES);
   localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;

   logic [GW-1:0]           ghr;
   logic [IDX-1:0]          ghr_x;
   bp_entry_t               tbl [NUM_ENTRIES];
   logic [IDX-1:0]          l_idx, u_idx;
   logic [TAG_BITS_MAX-1:0] l_tag, u_tag;
   bp_entry_t               l_ent, u_ent;
   logic                    u_hit;
   logic [CTR_BITS-1:0]     ctr_nxt [NUM_ENTRIES];
   logic                    unused_bits;

   // History only participates in gshare mode; prediction uses the
   // current (committed) history, never a speculative one.
   assign ghr_x = (GHR_BITS == 0) ? '0 : IDX'(ghr);

   assign l_idx = pred_pc[IDX+1:2] ^ ghr_x;
   assign l_tag = TAG_BITS_MAX'(pred_pc[31:IDX+2]);
   assign u_idx = update_pc[IDX+1:2] ^ ghr_x;
   assign u_tag = TAG_BITS_MAX'(update_pc[31:IDX+2]);

   // Reads see the registered table, so a same-cycle update to the
   // looked-up entry is not visible until the following cycle.
   assign l_ent       = tbl[l_idx];
   assign u_ent       = tbl[u_idx];
   assign pred_hit    = l_ent.valid && (l_ent.tag == l_tag);
   assign pred_taken  = pred_hit && l_ent.ctr[CTR_BITS-1];
   assign pred_target = pred_taken ? l_ent.target : pred_pc + 32'd4;
   assign u_hit       = u_ent.valid && (u_ent.tag == u_tag);

   // One counter stepper per entry; only the hit entry is stepped.
   for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ctr
      logic sel;
      assign sel = update_valid && u_hit && (u_idx == IDX'(i));
      sat_counter #(.W(CTR_BITS)) u_ctr (
         .cnt (tbl[i].ctr[CTR_BITS-1:0]),
         .inc (sel && update_taken),
         .dec (sel && !update_taken),
         .nxt (ctr_nxt[i])
      );
   end

   // Table and history state; reset wins over a simultaneous update.
   always_ff @(posedge clk) begin
      if (reset) begin
         ghr <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            tbl[i].valid  <= 1'b0;
            tbl[i].tag    <= '0;
            tbl[i].target <= '0;
            tbl[i].ctr    <= ctr_weak_not_taken(CTR_BITS);
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++)
            tbl[i].ctr <= CTR_BITS_MAX'(ctr_nxt[i]);
         if (update_valid) begin
            if (u_hit) begin
               if (update_taken)
                  tbl[u_idx].target <= update_target;
            end else if (update_taken) begin
               // Taken miss replaces whatever occupied the slot.
               tbl[u_idx].valid  <= 1'b1;
               tbl[u_idx].tag    <= u_tag;
               tbl[u_idx].target <= update_target;
               tbl[u_idx].ctr    <= ctr_weak_taken(CTR_BITS);
            end
            if (GHR_BITS > 0)
               ghr <= GW'({ghr, update_taken});
         end
      end
   end

   // Low PC bits and some record fields are intentionally not consumed.
   assign unused_bits = ^{pred_pc[1:0], update_pc[1:0], u_ent.ctr,
                          u_ent.target, l_ent.ctr};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal instance (b0) and gshare GHR_BITS=2 instance (b1)
// share clock, reset and stimulus; expectations are hand-computed.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pred_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;

   logic        hit0, tkn0, hit1, tkn1;
   logic [31:0] tgt0, tgt1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   branch_predictor #(.NUM_ENTRIES(16), .CTR_BITS(2), .GHR_BITS(0)) b0 (
      .clk(clk), .reset(reset), .pred_pc(pred_pc),
      .pred_hit(hit0), .pred_taken(tkn0), .pred_target(tgt0),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_taken(update_taken), .update_target(update_target)
   );

   branch_predictor #(.NUM_ENTRIES(16), .CTR_BITS(2), .GHR_BITS(2)) b1 (
      .clk(clk), .reset(reset), .pred_pc(pred_pc),
      .pred_hit(hit1), .pred_taken(tkn1), .pred_target(tgt1),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_taken(update_taken), .update_target(update_target)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one resolved update for a single cycle.
   task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
      update_valid  = 1'b1;
      update_pc     = pc;
      update_taken  = t;
      update_target = tgt;
      tick();
      update_valid  = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      pred_pc = pc;
      #1;
   endtask

   initial begin
      reset = 1'b1; update_valid = 1'b0; update_pc = '0;
      update_taken = 1'b0; update_target = '0; pred_pc = 32'h100;
      tick(); tick();
      reset = 1'b0;

      // Empty table after reset
      look(32'h100);
      check("rst_hit",    {31'd0, hit0}, 32'd0);
      check("rst_taken",  {31'd0, tkn0}, 32'd0);
      check("rst_target", tgt0, 32'h104);
      check("rst_hit_g",  {31'd0, hit1}, 32'd0);

      // Allocate 0x100 -> 0x40; same-cycle lookup still sees old contents
      update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h40;
      #1;
      check("same_cycle_hit", {31'd0, hit0}, 32'd0);
      tick(); update_valid = 1'b0;
      look(32'h100);
      check("alloc_hit",    {31'd0, hit0}, 32'd1);
      check("alloc_taken",  {31'd0, tkn0}, 32'd1);
      check("alloc_target", tgt0, 32'h40);

      // Counter 2 -> 1 -> 0 -> 0 (floor)
      upd(32'h100, 1'b0, 32'h0); look(32'h100);
      check("nt1_hit",    {31'd0, hit0}, 32'd1);
      check("nt1_taken",  {31'd0, tkn0}, 32'd0);
      check("nt1_target", tgt0, 32'h104);
      upd(32'h100, 1'b0, 32'h0); look(32'h100);
      check("nt2_taken",  {31'd0, tkn0}, 32'd0);
      upd(32'h100, 1'b0, 32'h0);
      // 0 -> 1 only if the floor held (a wrap to 3 would give 3 here)
      upd(32'h100, 1'b1, 32'h80); look(32'h100);
      check("floor_taken", {31'd0, tkn0}, 32'd0);
      upd(32'h100, 1'b1, 32'h80); look(32'h100);
      check("t2_taken",  {31'd0, tkn0}, 32'd1);
      check("t2_target", tgt0, 32'h80);

      // Counter 2 -> 3 -> 3 (ceiling) -> 2 on not-taken; target kept
      upd(32'h100, 1'b1, 32'h80);
      upd(32'h100, 1'b1, 32'h80);
      upd(32'h100, 1'b0, 32'h0); look(32'h100);
      check("ceil_taken",  {31'd0, tkn0}, 32'd1);
      check("ceil_target", tgt0, 32'h80);

      // Not-taken miss does not allocate
      upd(32'h300, 1'b0, 32'h0); look(32'h300);
      check("nt_miss_hit", {31'd0, hit0}, 32'd0);

      // 0x140 aliases 0x100's slot with a different tag
      upd(32'h140, 1'b1, 32'h500); look(32'h100);
      check("alias_old_hit", {31'd0, hit0}, 32'd0);
      look(32'h140);
      check("alias_new_hit",    {31'd0, hit0}, 32'd1);
      check("alias_new_target", tgt0, 32'h500);

      // pc+4 wraps
      look(32'hFFFF_FFFC);
      check("wrap_target",   tgt0, 32'h0);
      check("wrap_target_g", tgt1, 32'h0);

      // Fresh start for gshare checks
      reset = 1'b1; tick(); reset = 1'b0;
      look(32'h140);
      check("rst2_hit", {31'd0, hit0}, 32'd0);

      // T,T at 0x200: gshare allocates entry 0 (ghr=0) then entry 1 (ghr=1); ghr ends at 3
      upd(32'h200, 1'b1, 32'h600);
      upd(32'h200, 1'b1, 32'h600);
      look(32'h200);
      check("g_idx3_miss", {31'd0, hit1}, 32'd0);
      check("b_200_taken", {31'd0, tkn0}, 32'd1);
      look(32'h20C);
      check("g_idx0_hit",    {31'd0, hit1}, 32'd1);
      check("g_idx0_target", tgt1, 32'h600);
      look(32'h208);
      check("g_idx1_hit",    {31'd0, hit1}, 32'd1);
      look(32'h204);
      check("g_idx2_miss",   {31'd0, hit1}, 32'd0);

      // Reset during an update: the update is dropped and history clears
      reset = 1'b1;
      upd(32'h200, 1'b1, 32'h700);
      reset = 1'b0;
      look(32'h200);
      check("rst_upd_hit_b", {31'd0, hit0}, 32'd0);
      check("rst_upd_hit_g", {31'd0, hit1}, 32'd0);
      check("rst_upd_tgt_g", tgt1, 32'h204);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
